// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes,
// instruction field positions and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam int OP_LSB   = 6;
  localparam int DST_LSB  = 4;
  localparam int SRCA_LSB = 2;
  localparam int SRCB_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Initiator for a registered ALU: runs a short stored
// program over a 4-entry register file, one op per 3 cycles.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREGS = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PROG_WE,
  input  logic [AW-1:0]    PROG_ADDR,
  input  logic [7:0]       PROG_DATA,
  input  logic             REG_WE,
  input  logic [1:0]       REG_ADDR,
  input  logic [WIDTH-1:0] REG_DATA,
  output logic [WIDTH-1:0] REG_RDATA,
  input  logic             START,
  input  logic [AW:0]      LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       ALU_OPCODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALU_Y
);

  state_t state, state_n;

  logic [7:0]       prog [DEPTH];
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW:0]      pc, len, pc_inc, len_clamp;
  logic [7:0]       ir;

  assign ir        = prog[pc[AW-1:0]];
  assign pc_inc    = pc + 1'b1;
  assign len_clamp = (LEN > (AW+1)'(DEPTH)) ?
                     (AW+1)'(DEPTH) : LEN;

  assign BUSY      = (state == S_ISSUE) ||
                     (state == S_WAIT)  ||
                     (state == S_CAPTURE);
  assign DONE      = (state == S_FINISH);
  assign REG_RDATA = regs[REG_ADDR];

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (START)
          state_n = (LEN == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:   state_n = S_WAIT;
      S_WAIT:    state_n = S_CAPTURE;
      S_CAPTURE:
        state_n = (pc_inc == len) ? S_FINISH : S_ISSUE;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Program memory survives reset on purpose.
  always_ff @(posedge CLK) begin
    if (PROG_WE && !BUSY)
      prog[PROG_ADDR] <= PROG_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= '0;
      len        <= '0;
      ALU_OPCODE <= OP_ADD;
      ALU_A      <= '0;
      ALU_B      <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      if (state == S_IDLE && START) begin
        pc  <= '0;
        len <= len_clamp;
      end
      if (state == S_ISSUE) begin
        ALU_OPCODE <= ir[OP_LSB +: 2];
        ALU_A      <= regs[ir[SRCA_LSB +: 2]];
        ALU_B      <= regs[ir[SRCB_LSB +: 2]];
      end
      if (state == S_CAPTURE) begin
        regs[ir[DST_LSB +: 2]] <= ALU_Y;
        pc                     <= pc_inc;
      end
      if (REG_WE && !BUSY)
        regs[REG_ADDR] <= REG_DATA;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: registered ALU model, cycle model
// of the sequencer's schedule, directed runs with literal checks.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       CLK = 0;
  logic       RST = 1;
  logic       PROG_WE = 0;
  logic [3:0] PROG_ADDR = 0;
  logic [7:0] PROG_DATA = 0;
  logic       REG_WE = 0;
  logic [1:0] REG_ADDR = 0;
  logic [7:0] REG_DATA = 0;
  logic [7:0] REG_RDATA;
  logic       START = 0;
  logic [4:0] LEN = 0;
  logic       BUSY, DONE;
  logic [1:0] ALU_OPCODE;
  logic [7:0] ALU_A, ALU_B;
  logic [7:0] ALU_Y;

  int passed = 0;
  int total  = 0;

  alu_sequencer #(.WIDTH(8), .DEPTH(16), .NREGS(4)) dut (
    .CLK(CLK), .RST(RST),
    .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR),
    .PROG_DATA(PROG_DATA),
    .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .REG_DATA(REG_DATA), .REG_RDATA(REG_RDATA),
    .START(START), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE),
    .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A),
    .ALU_B(ALU_B), .ALU_Y(ALU_Y)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(
    input logic [1:0] op,
    input logic [7:0] a,
    input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return ~a;
    endcase
  endfunction

  // Registered ALU, one cycle of latency.
  always @(posedge CLK)
    ALU_Y <= alu_f(ALU_OPCODE, ALU_A, ALU_B);

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  // Schedule model: instruction k is issued t=3k cycles
  // after START is taken, written back at t=3k+2.
  logic [7:0] m_prog [16];
  logic [7:0] m_regs [4];
  logic [1:0] m_op;
  logic [7:0] m_a, m_b, m_ins;
  logic       m_act, m_done, was_done;
  int         m_t, m_len, k;

  initial begin
    for (int i = 0; i < 16; i++) m_prog[i] = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_op = 0; m_a = 0; m_b = 0;
    m_act = 0; m_done = 0; m_t = 0; m_len = 0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_op = 0; m_a = 0; m_b = 0;
      m_act = 0; m_done = 0; m_t = 0;
    end else if (!m_act) begin
      was_done = m_done;
      m_done = 0;
      if (PROG_WE) m_prog[PROG_ADDR] = PROG_DATA;
      if (REG_WE) m_regs[REG_ADDR] = REG_DATA;
      if (START && !was_done) begin
        m_len = (LEN > 16) ? 16 : int'(LEN);
        if (m_len == 0) m_done = 1;
        else begin m_act = 1; m_t = 0; end
      end
    end else begin
      k = m_t / 3;
      m_ins = m_prog[k];
      if (m_t % 3 == 0) begin
        m_op = m_ins[7:6];
        m_a = m_regs[m_ins[3:2]];
        m_b = m_regs[m_ins[1:0]];
      end else if (m_t % 3 == 2) begin
        m_regs[m_ins[5:4]] = alu_f(m_op, m_a, m_b);
        if (k + 1 == m_len) begin
          m_act = 0; m_done = 1;
        end
      end
      m_t++;
    end
  end

  initial begin
    @(posedge CLK);
    forever begin
      @(posedge CLK); #1;
      chk("busy", BUSY, m_act);
      chk("done", DONE, m_done);
      chk("alu_op", ALU_OPCODE, m_op);
      chk("alu_a", ALU_A, m_a);
      chk("alu_b", ALU_B, m_b);
      chk("rdata", REG_RDATA, m_regs[REG_ADDR]);
    end
  end

  task automatic wreg(input logic [1:0] a,
                      input logic [7:0] d);
    @(negedge CLK);
    REG_WE = 1; REG_ADDR = a; REG_DATA = d;
    @(negedge CLK);
    REG_WE = 0;
  endtask

  task automatic wprog(input logic [3:0] a,
                       input logic [7:0] d);
    @(negedge CLK);
    PROG_WE = 1; PROG_ADDR = a; PROG_DATA = d;
    @(negedge CLK);
    PROG_WE = 0;
  endtask

  task automatic rdreg(input logic [1:0] a,
                       input int exp, input string nm);
    @(negedge CLK);
    REG_ADDR = a;
    #1 chk(nm, REG_RDATA, exp);
  endtask

  // n counts cycles from the START cycle to the DONE cycle.
  task automatic run(input logic [4:0] l, input int exp,
                     input string nm, input int poke,
                     input bit wr, input logic [1:0] wa,
                     input logic [7:0] wd,
                     output logic [7:0] a2,
                     output logic [7:0] b2);
    int n;
    @(negedge CLK);
    START = 1; LEN = l;
    if (wr) begin
      REG_WE = 1; REG_ADDR = wa; REG_DATA = wd;
    end
    @(negedge CLK);
    START = 0; REG_WE = 0;
    n = 1;
    a2 = 0; b2 = 0;
    while (!DONE && n < 400) begin
      @(negedge CLK);
      n++;
      if (n == 2) begin a2 = ALU_A; b2 = ALU_B; end
      START = (n == poke);
      PROG_WE = (n == poke);
      if (n == poke) begin
        LEN = 0; PROG_ADDR = 5; PROG_DATA = 8'h21;
      end
    end
    START = 0; PROG_WE = 0;
    chk(nm, n, exp);
  endtask

  logic [7:0] a2, b2;

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_op", ALU_OPCODE, 0);
    chk("rst_a", ALU_A, 0);
    chk("rst_b", ALU_B, 0);
    for (int i = 0; i < 4; i++)
      rdreg(2'(i), 0, "rst_reg");

    // r2 = r0 + r1, r1 written alongside START
    wreg(0, 5);
    wprog(0, 8'h21);
    run(1, 4, "add_latency", -1, 1, 1, 7, a2, b2);
    chk("add_alu_a", a2, 5);
    chk("add_alu_b", b2, 7);
    rdreg(2, 12, "add_r2");

    // chain with wrap; START mid-run must be ignored
    wprog(0, 8'h21);
    wprog(1, 8'h79);
    wprog(2, 8'hBD);
    wprog(3, 8'hC0);
    wreg(0, 200);
    wreg(1, 100);
    run(4, 13, "chain_latency", 5, 0, 0, 0, a2, b2);
    rdreg(2, 44, "chain_r2");
    rdreg(3, 64, "chain_r3");
    rdreg(0, 55, "chain_r0");
    rdreg(1, 100, "chain_r1");

    run(0, 1, "len0_latency", -1, 0, 0, 0, a2, b2);
    rdreg(0, 55, "len0_r0");
    rdreg(3, 64, "len0_r3");

    // reset in WAIT of the second instruction
    wreg(0, 200);
    @(negedge CLK);
    START = 1; LEN = 4;
    @(negedge CLK);
    START = 0;
    repeat (4) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    for (int i = 0; i < 4; i++)
      rdreg(2'(i), 0, "abort_reg");
    wreg(0, 200);
    wreg(1, 100);
    run(4, 13, "rerun_latency", -1, 0, 0, 0, a2, b2);
    rdreg(2, 44, "rerun_r2");
    rdreg(3, 64, "rerun_r3");
    rdreg(0, 55, "rerun_r0");

    // full-depth NOT loop; program write while busy dropped
    for (int i = 0; i < 16; i++)
      wprog(4'(i), 8'hC0);
    wreg(0, 8'h5A);
    run(16, 49, "full_latency", 7, 0, 0, 0, a2, b2);
    rdreg(0, 8'h5A, "full_r0");
    run(31, 49, "clamp_latency", -1, 0, 0, 0, a2, b2);
    rdreg(0, 8'h5A, "clamp_r0");

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
